// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the data-memory bus arbiter: transfer sizes, FSM states, grant ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Winner selection between fetch and load/store requests (round robin when ARB_ROUND_ROBIN_EN).
// Latency: purely combinational.
// Backpressure: none; the loser simply keeps its request asserted.
module arb_grant_sel
  import mem_bus_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_gnt,
`endif
  output logic req_any,
  output logic gnt
);

  assign req_any = i_req | d_req;

  always_comb begin
    gnt = GNT_D;
    if (i_req && !d_req) begin
      gnt = GNT_I;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (i_req && d_req) begin
      gnt = ~last_gnt;
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and load/store; optional ARB_ROUND_ROBIN_EN arbitration.
// Latency: addr_ok same cycle, bus_req next cycle, data_ok combinational from bus_data_ok.
// Backpressure: one transaction in flight; losers hold their request, bus stalls hold the latched fields.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [1:0]        i_size,
  input  logic [AW-1:0]     i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DW-1:0]     i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [AW-1:0]     d_addr,
  input  logic [DW/8-1:0]   d_wstrb,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DW-1:0]     d_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [AW-1:0]     bus_addr,
  output logic [DW/8-1:0]   bus_wstrb,
  output logic [DW-1:0]     bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DW-1:0]     bus_rdata
);

  arb_state_t            state;
  logic                  gnt_q;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic [AW-1:0]         addr_q;
  logic [DW/8-1:0]       wstrb_q;
  logic [DW-1:0]         wdata_q;
  logic                  req_any;
  logic                  win;
  logic                  capture;
  logic                  rsp;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;
`endif

  arb_grant_sel u_grant_sel (
    .i_req    (i_req),
    .d_req    (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_gnt (last_gnt),
`endif
    .req_any  (req_any),
    .gnt      (win)
  );

  assign capture   = (state == ARB_IDLE) && req_any;
  assign i_addr_ok = capture && (win == GNT_I);
  assign d_addr_ok = capture && (win == GNT_D);

  // Response is only honoured in DATA; stray acks in IDLE/ADDR fall through.
  assign rsp       = (state == ARB_DATA) && bus_data_ok;
  assign i_data_ok = rsp && (gnt_q == GNT_I);
  assign d_data_ok = rsp && (gnt_q == GNT_D);
  assign i_rdata   = i_data_ok ? bus_rdata : '0;
  assign d_rdata   = d_data_ok ? bus_rdata : '0;

  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      bus_req <= 1'b0;
      gnt_q   <= GNT_I;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (req_any) begin
            state   <= ARB_ADDR;
            bus_req <= 1'b1;
            gnt_q   <= win;
            // Fetch side never writes; its write flag is deliberately masked off.
            wr_q    <= (win == GNT_D) ? d_wr : (i_wr & 1'b0);
            size_q  <= (win == GNT_D) ? d_size : i_size;
            addr_q  <= (win == GNT_D) ? d_addr : i_addr;
            wstrb_q <= ((win == GNT_D) && d_wr) ? d_wstrb : '0;
            wdata_q <= (win == GNT_D) ? d_wdata : '0;
          end
        end
        ARB_ADDR: begin
          if (bus_addr_ok) begin
            state   <= ARB_DATA;
            bus_req <= 1'b0;
          end
        end
        ARB_DATA: begin
          if (bus_data_ok) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset to d so the fetch side wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= GNT_D;
    end else if (capture) begin
      last_gnt <= win;
    end
  end
`endif

endmodule
